// File: rtl/ex_stage_muldiv.sv
// EX stage of the 5-stage RV32 pipeline with the M extension: operand forwarding,
// single-cycle ALU, iterative multiply/divide unit and the EX/MEM pipeline register.
module ex_stage_muldiv #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [XLEN-1:0]       reg_a_in,
  input  logic [XLEN-1:0]       reg_b_in,
  input  logic                  mem_to_reg_in,
  input  logic                  reg_write_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  beq_instruction_in,
  input  logic                  aluSrc_in,
  input  logic [1:0]            aluOp_in,
  input  logic [6:0]            funct7_in,
  input  logic [2:0]            funct3_in,
  input  logic [REG_ADDR_W-1:0] reg_rs1_in,
  input  logic [REG_ADDR_W-1:0] reg_rs2_in,
  input  logic [REG_ADDR_W-1:0] reg_rd_in,
  input  logic [XLEN-1:0]       immediate_in,
  input  logic [REG_ADDR_W-1:0] ex_mem_reg_rd,
  input  logic [REG_ADDR_W-1:0] mem_wb_reg_rd,
  input  logic                  ex_mem_reg_write,
  input  logic                  mem_wb_reg_write,
  input  logic [XLEN-1:0]       alu_ex_mem,
  input  logic [XLEN-1:0]       alu_data_mem_wb,
  input  logic                  flush_in,
  output logic                  ex_stall,
  output logic [REG_ADDR_W-1:0] rd_ex,
  output logic                  mem_to_reg_out,
  output logic                  reg_write_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic                  beq_instruction_out,
  output logic [XLEN-1:0]       alu_result_out,
  output logic [XLEN-1:0]       mux2_result_out,
  output logic [REG_ADDR_W-1:0] reg_rd_out,
  output logic                  flag_beq_out
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t                  state_r, state_nx_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [2*XLEN-1:0]       acc_r;
  logic [XLEN-1:0]         opb_r, a_orig_r, fwd_b_r;
  logic [2:0]              funct3_r;
  logic                    a_neg_r, b_neg_r, b_zero_r;
  logic [REG_ADDR_W-1:0]   rd_r;
  logic                    mem_to_reg_r, reg_write_r, mem_read_r, mem_write_r, beq_r;

  logic [XLEN-1:0]         fwd_a_s, fwd_b_s, alu_b_s, alu_res_s;
  logic [CNT_W-1:0]        shamt_s;
  logic                    is_m_s, issue_s, signed_a_s, signed_b_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]         mag_a_s, mag_b_s;
  logic [XLEN:0]           mul_sum_s, div_shift_s, div_diff_s;
  logic [2*XLEN-1:0]       mul_next_s, div_next_s, prod_fix_s;
  logic [XLEN-1:0]         quo_s, rem_s, m_res_s;

  logic                    nx_mem_to_reg_s, nx_reg_write_s, nx_mem_read_s, nx_mem_write_s, nx_beq_s;
  logic                    nx_flag_s;
  logic [XLEN-1:0]         nx_alu_s, nx_mux2_s;
  logic [REG_ADDR_W-1:0]   nx_rd_s;

  assign rd_ex = reg_rd_in;

  // Operand forwarding: EX/MEM beats MEM/WB, x0 never forwards
  always_comb begin
    if (ex_mem_reg_write && (ex_mem_reg_rd != {REG_ADDR_W{1'b0}}) && (ex_mem_reg_rd == reg_rs1_in)) begin
      fwd_a_s = alu_ex_mem;
    end else if (mem_wb_reg_write && (mem_wb_reg_rd != {REG_ADDR_W{1'b0}}) && (mem_wb_reg_rd == reg_rs1_in)) begin
      fwd_a_s = alu_data_mem_wb;
    end else begin
      fwd_a_s = reg_a_in;
    end
    if (ex_mem_reg_write && (ex_mem_reg_rd != {REG_ADDR_W{1'b0}}) && (ex_mem_reg_rd == reg_rs2_in)) begin
      fwd_b_s = alu_ex_mem;
    end else if (mem_wb_reg_write && (mem_wb_reg_rd != {REG_ADDR_W{1'b0}}) && (mem_wb_reg_rd == reg_rs2_in)) begin
      fwd_b_s = alu_data_mem_wb;
    end else begin
      fwd_b_s = reg_b_in;
    end
  end

  assign alu_b_s = aluSrc_in ? immediate_in : fwd_b_s;
  assign shamt_s = alu_b_s[CNT_W-1:0];

  // Single-cycle ALU; aluOp 00 add (ld/st), 01 sub (branch), 10 R-type, 11 I-type
  always_comb begin
    alu_res_s = fwd_a_s + alu_b_s;
    case (aluOp_in)
      2'b00: alu_res_s = fwd_a_s + alu_b_s;
      2'b01: alu_res_s = fwd_a_s - alu_b_s;
      2'b10, 2'b11: begin
        case (funct3_in)
          3'b000: begin
            if ((aluOp_in == 2'b10) && funct7_in[5]) alu_res_s = fwd_a_s - alu_b_s;
            else                                     alu_res_s = fwd_a_s + alu_b_s;
          end
          3'b001: alu_res_s = fwd_a_s << shamt_s;
          3'b010: alu_res_s = {{(XLEN-1){1'b0}}, ($signed(fwd_a_s) < $signed(alu_b_s))};
          3'b011: alu_res_s = {{(XLEN-1){1'b0}}, (fwd_a_s < alu_b_s)};
          3'b100: alu_res_s = fwd_a_s ^ alu_b_s;
          3'b101: begin
            if (funct7_in[5]) alu_res_s = $unsigned($signed(fwd_a_s) >>> shamt_s);
            else              alu_res_s = fwd_a_s >> shamt_s;
          end
          3'b110: alu_res_s = fwd_a_s | alu_b_s;
          3'b111: alu_res_s = fwd_a_s & alu_b_s;
          default: alu_res_s = fwd_a_s + alu_b_s;
        endcase
      end
      default: alu_res_s = fwd_a_s + alu_b_s;
    endcase
  end

  assign is_m_s     = (aluOp_in == 2'b10) && (funct7_in == 7'b0000001);
  assign issue_s    = (state_r == IDLE) && is_m_s && !flush_in;
  assign signed_a_s = (funct3_in == 3'b001) || (funct3_in == 3'b010) ||
                      (funct3_in == 3'b100) || (funct3_in == 3'b110);
  assign signed_b_s = (funct3_in == 3'b001) || (funct3_in == 3'b100) || (funct3_in == 3'b110);
  assign a_neg_s    = signed_a_s && fwd_a_s[XLEN-1];
  assign b_neg_s    = signed_b_s && fwd_b_s[XLEN-1];
  assign mag_a_s    = a_neg_s ? ({XLEN{1'b0}} - fwd_a_s) : fwd_a_s;
  assign mag_b_s    = b_neg_s ? ({XLEN{1'b0}} - fwd_b_s) : fwd_b_s;

  // acc holds {hi, multiplier} for mul and {remainder, dividend/quotient} for div
  assign mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
  assign mul_next_s  = {mul_sum_s, acc_r[XLEN-1:1]};
  assign div_shift_s = acc_r[2*XLEN-1:XLEN-1];
  assign div_diff_s  = div_shift_s - {1'b0, opb_r};
  assign div_next_s  = div_diff_s[XLEN] ? {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0}
                                        : {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};

  // Sign fix-up of the magnitude result and the divide-by-zero override
  always_comb begin
    prod_fix_s = (a_neg_r ^ b_neg_r) ? ({(2*XLEN){1'b0}} - acc_r) : acc_r;
    if (b_zero_r) begin
      quo_s = {XLEN{1'b1}};
      rem_s = a_orig_r;
    end else begin
      quo_s = (a_neg_r ^ b_neg_r) ? ({XLEN{1'b0}} - acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
      rem_s = a_neg_r ? ({XLEN{1'b0}} - acc_r[2*XLEN-1:XLEN]) : acc_r[2*XLEN-1:XLEN];
    end
    case (funct3_r)
      3'b000:                 m_res_s = prod_fix_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: m_res_s = prod_fix_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         m_res_s = quo_s;
      3'b110, 3'b111:         m_res_s = rem_s;
      default:                m_res_s = prod_fix_s[XLEN-1:0];
    endcase
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nx_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (issue_s) state_nx_s = BUSY;
        else         state_nx_s = IDLE;
      end
      BUSY: begin
        if (flush_in)                          state_nx_s = IDLE;
        else if (cnt_r == CNT_W'(XLEN - 1))    state_nx_s = DONE;
        else                                   state_nx_s = BUSY;
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM outputs: stall and the value EX/MEM captures next edge (bubble by default)
  always_comb begin
    ex_stall        = 1'b0;
    nx_mem_to_reg_s = 1'b0;
    nx_reg_write_s  = 1'b0;
    nx_mem_read_s   = 1'b0;
    nx_mem_write_s  = 1'b0;
    nx_beq_s        = 1'b0;
    nx_alu_s        = {XLEN{1'b0}};
    nx_mux2_s       = {XLEN{1'b0}};
    nx_rd_s         = {REG_ADDR_W{1'b0}};
    nx_flag_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (flush_in) begin
          ex_stall = 1'b0;
        end else if (is_m_s) begin
          ex_stall = !reset;
        end else begin
          nx_mem_to_reg_s = mem_to_reg_in;
          nx_reg_write_s  = reg_write_in;
          nx_mem_read_s   = mem_read_in;
          nx_mem_write_s  = mem_write_in;
          nx_beq_s        = beq_instruction_in;
          nx_alu_s        = alu_res_s;
          nx_mux2_s       = fwd_b_s;
          nx_rd_s         = reg_rd_in;
          nx_flag_s       = (alu_res_s == {XLEN{1'b0}});
        end
      end
      BUSY: begin
        ex_stall = !flush_in && !reset;
      end
      DONE: begin
        if (flush_in) begin
          ex_stall = 1'b0;
        end else begin
          nx_mem_to_reg_s = mem_to_reg_r;
          nx_reg_write_s  = reg_write_r;
          nx_mem_read_s   = mem_read_r;
          nx_mem_write_s  = mem_write_r;
          nx_beq_s        = beq_r;
          nx_alu_s        = m_res_s;
          nx_mux2_s       = fwd_b_r;
          nx_rd_s         = rd_r;
        end
      end
      default: ex_stall = 1'b0;
    endcase
  end

  // Mul/div datapath: latch operands at issue, one iteration per BUSY cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r        <= {CNT_W{1'b0}};
      acc_r        <= {(2*XLEN){1'b0}};
      opb_r        <= {XLEN{1'b0}};
      a_orig_r     <= {XLEN{1'b0}};
      fwd_b_r      <= {XLEN{1'b0}};
      funct3_r     <= 3'b000;
      a_neg_r      <= 1'b0;
      b_neg_r      <= 1'b0;
      b_zero_r     <= 1'b0;
      rd_r         <= {REG_ADDR_W{1'b0}};
      mem_to_reg_r <= 1'b0;
      reg_write_r  <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      beq_r        <= 1'b0;
    end else if (issue_s) begin
      cnt_r        <= {CNT_W{1'b0}};
      acc_r        <= {{XLEN{1'b0}}, mag_a_s};
      opb_r        <= mag_b_s;
      a_orig_r     <= fwd_a_s;
      fwd_b_r      <= fwd_b_s;
      funct3_r     <= funct3_in;
      a_neg_r      <= a_neg_s;
      b_neg_r      <= b_neg_s;
      b_zero_r     <= (fwd_b_s == {XLEN{1'b0}});
      rd_r         <= reg_rd_in;
      mem_to_reg_r <= mem_to_reg_in;
      reg_write_r  <= reg_write_in;
      mem_read_r   <= mem_read_in;
      mem_write_r  <= mem_write_in;
      beq_r        <= beq_instruction_in;
    end else if (state_r == BUSY) begin
      cnt_r <= cnt_r + CNT_W'(1);
      acc_r <= funct3_r[2] ? div_next_s : mul_next_s;
    end else begin
      cnt_r <= cnt_r;
      acc_r <= acc_r;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_to_reg_out      <= 1'b0;
      reg_write_out       <= 1'b0;
      mem_read_out        <= 1'b0;
      mem_write_out       <= 1'b0;
      beq_instruction_out <= 1'b0;
      alu_result_out      <= {XLEN{1'b0}};
      mux2_result_out     <= {XLEN{1'b0}};
      reg_rd_out          <= {REG_ADDR_W{1'b0}};
      flag_beq_out        <= 1'b0;
    end else begin
      mem_to_reg_out      <= nx_mem_to_reg_s;
      reg_write_out       <= nx_reg_write_s;
      mem_read_out        <= nx_mem_read_s;
      mem_write_out       <= nx_mem_write_s;
      beq_instruction_out <= nx_beq_s;
      alu_result_out      <= nx_alu_s;
      mux2_result_out     <= nx_mux2_s;
      reg_rd_out          <= nx_rd_s;
      flag_beq_out        <= nx_flag_s;
    end
  end

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Directed self-checking bench for ex_stage_muldiv (XLEN=32): forwarding, ALU,
// every M op including divide corner cases, flush abort and reset mid-operation.
module tb_ex_stage_muldiv;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] reg_a_in, reg_b_in, immediate_in, alu_ex_mem, alu_data_mem_wb;
  logic        mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in, beq_instruction_in;
  logic        aluSrc_in, ex_mem_reg_write, mem_wb_reg_write, flush_in;
  logic [1:0]  aluOp_in;
  logic [6:0]  funct7_in;
  logic [2:0]  funct3_in;
  logic [4:0]  reg_rs1_in, reg_rs2_in, reg_rd_in, ex_mem_reg_rd, mem_wb_reg_rd;
  logic        ex_stall;
  logic [4:0]  rd_ex, reg_rd_out;
  logic        mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out, beq_instruction_out;
  logic [31:0] alu_result_out, mux2_result_out;
  logic        flag_beq_out;

  int checks = 0;
  int errors = 0;

  ex_stage_muldiv #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clock(clock), .reset(reset),
    .reg_a_in(reg_a_in), .reg_b_in(reg_b_in),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .beq_instruction_in(beq_instruction_in),
    .aluSrc_in(aluSrc_in), .aluOp_in(aluOp_in), .funct7_in(funct7_in), .funct3_in(funct3_in),
    .reg_rs1_in(reg_rs1_in), .reg_rs2_in(reg_rs2_in), .reg_rd_in(reg_rd_in),
    .immediate_in(immediate_in),
    .ex_mem_reg_rd(ex_mem_reg_rd), .mem_wb_reg_rd(mem_wb_reg_rd),
    .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_reg_write(mem_wb_reg_write),
    .alu_ex_mem(alu_ex_mem), .alu_data_mem_wb(alu_data_mem_wb),
    .flush_in(flush_in), .ex_stall(ex_stall), .rd_ex(rd_ex),
    .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .beq_instruction_out(beq_instruction_out),
    .alu_result_out(alu_result_out), .mux2_result_out(mux2_result_out),
    .reg_rd_out(reg_rd_out), .flag_beq_out(flag_beq_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_nop();
    reg_a_in = 32'd0; reg_b_in = 32'd0; immediate_in = 32'd0;
    mem_to_reg_in = 1'b0; reg_write_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    beq_instruction_in = 1'b0; aluSrc_in = 1'b0; aluOp_in = 2'b00;
    funct7_in = 7'd0; funct3_in = 3'd0;
    reg_rs1_in = 5'd0; reg_rs2_in = 5'd0; reg_rd_in = 5'd0;
    ex_mem_reg_rd = 5'd0; mem_wb_reg_rd = 5'd0; ex_mem_reg_write = 1'b0; mem_wb_reg_write = 1'b0;
    alu_ex_mem = 32'd0; alu_data_mem_wb = 32'd0; flush_in = 1'b0;
  endtask

  task automatic set_add(input logic [31:0] a, input logic [31:0] b);
    set_nop();
    aluOp_in = 2'b10; reg_a_in = a; reg_b_in = b;
    reg_rs1_in = 5'd1; reg_rs2_in = 5'd2; reg_rd_in = 5'd3; reg_write_in = 1'b1;
  endtask

  task automatic set_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    set_nop();
    aluOp_in = 2'b10; funct7_in = 7'b0000001; funct3_in = f3;
    reg_a_in = a; reg_b_in = b;
    reg_rs1_in = 5'd6; reg_rs2_in = 5'd7; reg_rd_in = 5'd5; reg_write_in = 1'b1;
  endtask

  // Issue one M op, count stall cycles, scramble the forwarding inputs mid-op, check result
  task automatic run_m(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int cnt;
    set_m(f3, a, b);
    #1;
    chk({tag, " stall@issue"}, {31'd0, ex_stall}, 32'd1);
    cnt = 0;
    while (ex_stall === 1'b1 && cnt < 100) begin
      step();
      cnt++;
      if (cnt == 1) begin
        reg_a_in = 32'hDEADBEEF; reg_b_in = 32'h12345678;
        ex_mem_reg_write = 1'b1; ex_mem_reg_rd = 5'd6; alu_ex_mem = 32'h0BAD0BAD;
      end
    end
    chk({tag, " stall cycles"}, 32'(cnt), 32'd33);
    chk({tag, " no wb before done"}, {31'd0, reg_write_out}, 32'd0);
    step();
    chk({tag, " result"}, alu_result_out, exp);
    chk({tag, " reg_write"}, {31'd0, reg_write_out}, 32'd1);
    chk({tag, " rd"}, {27'd0, reg_rd_out}, 32'd5);
    chk({tag, " flag"}, {31'd0, flag_beq_out}, 32'd0);
    set_nop();
    #1;
    chk({tag, " stall after"}, {31'd0, ex_stall}, 32'd0);
  endtask

  initial begin
    int pulses;
    set_nop();
    reset = 1'b1;
    step();
    step();
    chk("reset alu", alu_result_out, 32'd0);
    chk("reset ctl", {27'd0, mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out,
                      beq_instruction_out}, 32'd0);
    chk("reset rd/flag", {26'd0, reg_rd_out, flag_beq_out}, 32'd0);
    chk("reset stall", {31'd0, ex_stall}, 32'd0);
    reset = 1'b0;

    // add with EX/MEM (5) and MEM/WB (9) both targeting rs1: EX/MEM wins
    set_add(32'd100, 32'd7);
    ex_mem_reg_write = 1'b1; ex_mem_reg_rd = 5'd1; alu_ex_mem = 32'd5;
    mem_wb_reg_write = 1'b1; mem_wb_reg_rd = 5'd1; alu_data_mem_wb = 32'd9;
    #1;
    chk("add stall", {31'd0, ex_stall}, 32'd0);
    chk("rd_ex", {27'd0, rd_ex}, 32'd3);
    step();
    chk("fwd exmem alu", alu_result_out, 32'd12);
    chk("fwd exmem ctl", {27'd0, reg_rd_out}, 32'd3);
    chk("fwd exmem mux2", mux2_result_out, 32'd7);

    // rd=0 never forwards
    reg_rs1_in = 5'd0; reg_a_in = 32'd20; ex_mem_reg_rd = 5'd0;
    step();
    chk("x0 no fwd", alu_result_out, 32'd27);

    // MEM/WB forwarding on B
    reg_rs1_in = 5'd1; ex_mem_reg_write = 1'b0; ex_mem_reg_rd = 5'd1;
    mem_wb_reg_rd = 5'd2;
    step();
    chk("fwd memwb alu", alu_result_out, 32'd29);
    chk("fwd memwb mux2", mux2_result_out, 32'd9);

    // sub to zero sets flag
    set_add(32'd7, 32'd7);
    funct7_in = 7'b0100000;
    step();
    chk("sub zero", alu_result_out, 32'd0);
    chk("sub flag", {31'd0, flag_beq_out}, 32'd1);

    // store-style add with immediate; mux2 keeps register B
    set_nop();
    aluSrc_in = 1'b1; immediate_in = 32'hFFFFFFF0; reg_a_in = 32'd100; reg_b_in = 32'd55;
    mem_write_in = 1'b1; reg_rs2_in = 5'd4;
    step();
    chk("imm alu", alu_result_out, 32'd84);
    chk("imm mux2", mux2_result_out, 32'd55);
    chk("imm memwrite", {30'd0, mem_write_out, reg_write_out}, 32'd2);

    run_m("MUL",    3'd0, 32'hFFFFFFFD, 32'd7,          32'hFFFFFFEB);
    run_m("MULHU",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF,   32'hFFFFFFFE);
    run_m("MULH",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,   32'h00000000);
    run_m("MULHSU", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,   32'hFFFFFFFF);
    run_m("DIV0",   3'd4, 32'd7,        32'd0,          32'hFFFFFFFF);
    run_m("REM0",   3'd6, 32'd7,        32'd0,          32'd7);
    run_m("DIVOV",  3'd4, 32'h80000000, 32'hFFFFFFFF,   32'h80000000);
    run_m("REMOV",  3'd6, 32'h80000000, 32'hFFFFFFFF,   32'd0);
    run_m("REMNEG", 3'd6, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF);
    run_m("DIVU",   3'd5, 32'd100,      32'd7,          32'd14);
    run_m("REMU",   3'd7, 32'd100,      32'd7,          32'd2);

    // flush at BUSY cycle 10
    set_m(3'd0, 32'd3, 32'd5);
    #1;
    step();
    repeat (10) step();
    flush_in = 1'b1;
    #1;
    chk("flush stall low", {31'd0, ex_stall}, 32'd0);
    step();
    set_add(32'd3, 32'd4);
    #1;
    chk("flush bubble", {31'd0, reg_write_out}, 32'd0);
    chk("flush then add stall", {31'd0, ex_stall}, 32'd0);
    step();
    chk("add after flush", alu_result_out, 32'd7);
    chk("add after flush wb", {31'd0, reg_write_out}, 32'd1);
    set_nop();
    pulses = 0;
    repeat (40) begin
      step();
      if (reg_write_out !== 1'b0) pulses++;
    end
    chk("no late wb after flush", 32'(pulses), 32'd0);

    // reset at BUSY cycle 5
    set_m(3'd5, 32'd100, 32'd7);
    #1;
    repeat (6) step();
    chk("busy stall", {31'd0, ex_stall}, 32'd1);
    reset = 1'b1;
    step();
    set_nop();
    #1;
    chk("rst mid alu", alu_result_out, 32'd0);
    chk("rst mid ctl", {27'd0, mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out,
                        beq_instruction_out}, 32'd0);
    chk("rst mid stall", {31'd0, ex_stall}, 32'd0);
    reset = 1'b0;
    set_add(32'd10, 32'd20);
    #1;
    chk("post rst add stall", {31'd0, ex_stall}, 32'd0);
    step();
    chk("post rst add", alu_result_out, 32'd30);
    run_m("DIVU2", 3'd5, 32'd100, 32'd7, 32'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
